// File: rtl/logicnets_dump_pkg.sv
// logicnets_dump_pkg: shared FSM states, counter-width helper and elaboration check for the LUT table dumper
`define LOGICNETS_DUMP_CHECK(name, cond, msg) if (!(cond)) begin : name $error(msg); end
package logicnets_dump_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lut_table_dumper.sv
// lut_table_dumper: sweeps every input code of a LUT neuron and streams its packed truth table
module lut_table_dumper
  import logicnets_dump_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_BITS-1:0]  lut_addr,
  input  logic [OUT_BITS-1:0] lut_data,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);
  localparam int EPW    = WORD_W / OUT_BITS;
  localparam int NWORDS = (2 ** IN_BITS) * OUT_BITS / WORD_W;
  localparam int SW     = cnt_w(EPW);
  localparam int CW     = cnt_w(NWORDS);
  `LOGICNETS_DUMP_CHECK(g_word_div, WORD_W % OUT_BITS == 0, "WORD_W must be a multiple of OUT_BITS")
  `LOGICNETS_DUMP_CHECK(g_table_div, ((2 ** IN_BITS) * OUT_BITS) % WORD_W == 0, "table size must be a multiple of WORD_W")
  logic [1:0]        state;
  logic [WORD_W-1:0] acc, acc_next;
  logic [SW-1:0]     slot;
  logic [CW-1:0]     word_cnt;
  logic              slot_end, hs;
  always_comb begin
    acc_next = acc;
    acc_next[slot * OUT_BITS +: OUT_BITS] = lut_data;
  end
  assign slot_end = slot == SW'(EPW - 1);
  assign hs       = out_valid && out_ready;
  assign busy     = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lut_addr  <= '0;
      acc       <= '0;
      slot      <= '0;
      word_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= FILL;
          lut_addr <= '0;
          slot     <= '0;
          word_cnt <= '0;
        end
        FILL: begin
          acc      <= acc_next;
          lut_addr <= lut_addr + IN_BITS'(1);
          slot     <= slot_end ? '0 : slot + SW'(1);
          if (slot_end) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            out_last  <= word_cnt == CW'(NWORDS - 1);
            state     <= SEND;
          end
        end
        SEND: if (hs) begin
          out_valid <= 1'b0;
          slot      <= '0;
          done      <= out_last;
          state     <= out_last ? IDLE : FILL;
          word_cnt  <= out_last ? word_cnt : word_cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_table_dumper.sv
// tb_lut_table_dumper: table-driven scoreboard bench for 1-bit and 2-bit neuron table dumps
module tb_lut_table_dumper;
  typedef struct {
    int          d;
    int          sel;
    bit          stl;
    bit          inj;
    logic [31:0] w;
    int          nw;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        st [2];
  logic        bz [2];
  logic        dn [2];
  logic        ov [2];
  logic        ol [2];
  logic [7:0]  la [2];
  logic [31:0] od [2];
  logic        ld0;
  logic [1:0]  ld1;
  logic        out_ready;
  logic        stall;
  int          scnt;
  int          sel0;
  int          n_checks, n_fail;
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  int          words_rx [2];
  int          done_cnt [2];
  logic        pend [2];
  logic [32:0] pend_val [2];
  vec_t        tab [7];
  always #5 clk = ~clk;
  assign ld0 = sel0 == 0 ? la[0][1] : sel0 == 1 ? la[0][0] : 1'b0;
  assign ld1 = la[1][1:0];
  lut_table_dumper u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .busy(bz[0]), .done(dn[0]),
    .lut_addr(la[0]), .lut_data(ld0), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .out_last(ol[0])
  );
  lut_table_dumper #(.OUT_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .busy(bz[1]), .done(dn[1]),
    .lut_addr(la[1]), .lut_data(ld1), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .out_last(ol[1])
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic mon(input int d);
    logic [32:0] cur, e;
    cur = {ol[d], od[d]};
    if (pend[d]) chk("stall_hold", {ov[d], cur}, {1'b1, pend_val[d]});
    pend[d] = ov[d] && !out_ready;
    pend_val[d] = cur;
    if (dn[d]) done_cnt[d]++;
    if (ov[d] && out_ready) begin
      words_rx[d]++;
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: dut%0d got %0h expected no word", d, cur);
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk("word", cur, e);
      end
    end
  endtask
  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);
  always @(posedge clk) begin
    #1;
    if (!stall) out_ready = 1'b1;
    else if (ov[0] && scnt < 5) begin
      out_ready = 1'b0;
      scnt++;
    end else begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_ready) scnt = 0;
    end
  end
  task automatic push_words(input int d, input logic [31:0] w, input int nw);
    for (int k = 0; k < nw; k++)
      if (d == 0) q0.push_back({k == nw - 1, w});
      else q1.push_back({k == nw - 1, w});
  endtask
  task automatic pulse_start(input int d);
    @(posedge clk);
    #2 st[d] = 1'b1;
    @(posedge clk);
    #2 st[d] = 1'b0;
  endtask
  task automatic run_dump(input vec_t v);
    int cyc, rx0, dc0;
    bit i1, i2;
    i1 = 0;
    i2 = 0;
    if (v.d == 0) sel0 = v.sel;
    stall = v.stl;
    scnt = 0;
    push_words(v.d, v.w, v.nw);
    rx0 = words_rx[v.d];
    dc0 = done_cnt[v.d];
    pulse_start(v.d);
    chk("busy_after_start", bz[v.d], 1);
    cyc = 0;
    while (!ov[v.d] && cyc < 200) begin
      @(posedge clk);
      #2 cyc++;
    end
    chk("first_valid_latency", cyc, v.d == 0 ? 32 : 16);
    cyc = 0;
    while (!dn[v.d] && cyc < 8000) begin
      @(posedge clk);
      #2 cyc++;
      st[v.d] = 1'b0;
      if (v.inj && words_rx[v.d] - rx0 == 3 && !i1) begin
        st[v.d] = 1'b1;
        i1 = 1;
      end
      if (v.inj && ov[v.d] && ol[v.d] && out_ready && !i2) begin
        st[v.d] = 1'b1;
        i2 = 1;
      end
    end
    st[v.d] = 1'b0;
    chk("done_seen", dn[v.d], 1);
    chk("busy_at_done", bz[v.d], 0);
    chk("addr_after_done", la[v.d], 0);
    if (v.inj) chk("starts_injected", {i1, i2}, 2'b11);
    @(posedge clk);
    #2 chk("done_one_cycle", dn[v.d], 0);
    repeat (3) @(posedge clk);
    #2 chk("done_count", done_cnt[v.d] - dc0, 1);
    chk("word_count", words_rx[v.d] - rx0, v.nw);
    chk("queue_empty", v.d == 0 ? q0.size() : q1.size(), 0);
    chk("idle_after", bz[v.d], 0);
  endtask
  initial begin
    int rx0, dc0, cyc;
    vec_t v;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    st[0] = 1'b0;
    st[1] = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    out_ready = 1'b1;
    stall = 1'b0;
    scnt = 0;
    sel0 = 0;
    tab[0] = '{0, 0, 1'b0, 1'b0, 32'hCCCC_CCCC, 8};
    tab[1] = '{0, 1, 1'b0, 1'b0, 32'hAAAA_AAAA, 8};
    tab[2] = '{0, 2, 1'b0, 1'b0, 32'h0000_0000, 8};
    tab[3] = '{1, 3, 1'b0, 1'b0, 32'hE4E4_E4E4, 16};
    tab[4] = '{0, 0, 1'b1, 1'b0, 32'hCCCC_CCCC, 8};
    tab[5] = '{0, 1, 1'b1, 1'b0, 32'hAAAA_AAAA, 8};
    tab[6] = '{0, 0, 1'b0, 1'b1, 32'hCCCC_CCCC, 8};
    #12;
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_last", ol[0], 0);
    chk("rst_out_data", od[0], 0);
    chk("rst_busy", bz[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_addr", la[0], 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk("idle_addr_hold", la[0], 0);
    for (int i = 0; i < 7; i++) run_dump(tab[i]);
    sel0 = 0;
    stall = 1'b0;
    push_words(0, 32'hCCCC_CCCC, 8);
    rx0 = words_rx[0];
    dc0 = done_cnt[0];
    pulse_start(0);
    cyc = 0;
    while (words_rx[0] - rx0 < 3 && cyc < 2000) begin
      @(posedge clk);
      #2 cyc++;
    end
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", ov[0], 0);
    chk("abort_out_last", ol[0], 0);
    chk("abort_out_data", od[0], 0);
    chk("abort_busy", bz[0], 0);
    chk("abort_addr", la[0], 0);
    q0.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk("abort_no_done", done_cnt[0] - dc0, 0);
    chk("abort_no_partial", words_rx[0] - rx0, 3);
    v = '{0, 0, 1'b0, 1'b0, 32'hCCCC_CCCC, 8};
    run_dump(v);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lut_table_dumper.md
Name: lut_table_dumper

Overview:
- Reads back the full truth table of one combinational LUT neuron (IN_BITS-in, OUT_BITS-out) by sweeping every input code.
- Packs the neuron outputs LSB-first into WORD_W-bit words and streams them out over a valid/ready interface.
- Sits beside a generated layer neuron in the dump/debug path: the read side of the table that neuron generation writes.

Parameters:
- IN_BITS, 8, neuron input width; the table has 2^IN_BITS entries.
- OUT_BITS, 1, neuron output width per entry.
- WORD_W, 32, output word width. WORD_W % OUT_BITS == 0 and (2^IN_BITS*OUT_BITS) % WORD_W == 0, both checked at elaboration.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until the final word handshake.
- done  out  1  one-cycle pulse in the cycle after the final word handshake.
- lut_addr  out  IN_BITS  registered input code driven to the neuron input.
- lut_data  in  OUT_BITS  neuron output, combinational from lut_addr.
- out_data  out  WORD_W  packed table word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  high with out_valid on the final word.

Behaviour:
- Reset (async assert, sync release) values: state=IDLE, lut_addr=0, acc=0, slot=0, word_cnt=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
- Derived constants: EPW = WORD_W/OUT_BITS entries per word; NWORDS = 2^IN_BITS*OUT_BITS/WORD_W.
- IDLE:
  - start=1 -> FILL; lut_addr=0, slot=0, word_cnt=0.
  - start=0 -> hold; lut_addr stays 0.
- FILL:
  - Each cycle, lut_data is written into acc[slot*OUT_BITS +: OUT_BITS]; lut_addr increments; slot increments.
  - On the cycle slot==EPW-1: out_data <= acc with the current entry merged in; out_valid <= 1; out_last <= (word_cnt==NWORDS-1) -> SEND.
- SEND:
  - out_data, out_valid and out_last are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid <= 0; slot <= 0.
  - If out_last: -> IDLE, done pulses next cycle, busy drops.
  - Otherwise: word_cnt++ -> FILL.
  - lut_addr does not change in SEND.
- Address wrap:
  - lut_addr is IN_BITS wide and wraps 2^IN_BITS-1 -> 0 exactly on the last FILL cycle.
  - On return to IDLE it therefore reads 0.
- Latency and throughput:
  - First out_valid rises EPW cycles after the start-accept edge.
  - Steady-state word period is EPW+1 cycles with out_ready held high.
- Packing: table entry i occupies out_data bits [(i%EPW)*OUT_BITS +: OUT_BITS] of word floor(i/EPW). Words are emitted in increasing order.
- Boundary cases:
  - start while busy is ignored, with no restart and no glitch on outputs.
  - start in the same cycle as the final handshake is ignored, because the state is not yet IDLE.
  - out_ready asserted while out_valid=0 has no effect.
  - rst_n asserted mid-dump aborts immediately to reset values; no done pulse and no partial word are emitted.

Decomposition:
- Shared package (logicnets_dump_pkg):
  - state enum {IDLE, FILL, SEND};
  - function clog2-based widths for slot and word_cnt;
  - elaboration-check macro for the divisibility rules.
- No sub-module: the FSM, counters and packing register all sit in one module.
- Bench instantiates the target neuron as DUT companion.

Test Plan:
- Neuron out = M0[1], defaults, out_ready=1, pulse start -> 8 words each 0xCCCCCCCC; out_last only on word 8; done one cycle after; first out_valid 32 cycles after start edge.
- Neuron out = M0[0] -> 8 words 0xAAAAAAAA; constant-0 neuron -> 8 words 0x00000000; lut_addr reads 0 after done.
- OUT_BITS=2, neuron out = M0[1:0] -> 16 words each 0xE4E4E4E4; out_last on word 16.
- out_ready low 5 cycles per word (random stall pattern) -> out_data/out_last stable while stalled, same word sequence as test 1, no lost or duplicated words.
- start pulsed again at word 3 and in final-handshake cycle -> ignored; exactly 8 words and a single done.
- rst_n low during word 4 FILL -> all outputs at reset values asynchronously; a new start afterwards yields a complete correct 8-word dump.
